window3x3_linebuf: RTL and testbench

- Consumes the registered raster pixel stream produced by the UART pixel feeder (valid_in/px_in): one pixel per valid cycle, row-major, no backpressure.
- Buffers the two previous image lines and emits one complete 3x3 neighbourhood per accepted pixel once the neighbourhood exists.
- Output feeds the 2D convolution datapath directly. Windows cover image interior only; no padding.

---
 rtl/window3x3_linebuf.sv | 209 ++++++++++++++++++++
 tb/tb_window3x3_linebuf.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/window3x3_linebuf.sv
// ---------------------------------------------------------------------------
// window3x3_linebuf
//
// Turns a row-major raster pixel stream into a stream of complete 3x3
// neighbourhoods. Two line buffers hold the previous two image lines. A 3x3
// window register slides one column to the right on every accepted pixel.
// One window is emitted per accepted pixel once that pixel has two full
// lines above it and two full columns to its left. Only interior windows are
// produced, so there is no border padding.
//
// Parameters
//   PIX_W  pixel width in bits
//   IMG_W  image width in pixels  (>= 3)
//   IMG_H  image height in pixels (>= 3)
//
// Ports
//   clk         system clock
//   rst         synchronous reset, active-high
//   valid_in    pixel strobe; one pixel per high cycle, no backpressure
//   px_in       pixel value, sampled when valid_in = 1
//   valid_out   win_out / row_out / col_out are valid this cycle
//   win_out     3x3 window. Element k = 3*r + c sits at [k*PIX_W +: PIX_W].
//               r = 0 is the oldest line and c = 0 is the oldest column.
//   row_out     row of the window centre
//   col_out     column of the window centre
//   frame_done  one-cycle pulse alongside the last window of a frame
// ---------------------------------------------------------------------------
module window3x3_linebuf #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_in,
  input  logic [PIX_W-1:0]          px_in,
  output logic                      valid_out,
  output logic [9*PIX_W-1:0]        win_out,
  output logic [$clog2(IMG_H)-1:0]  row_out,
  output logic [$clog2(IMG_W)-1:0]  col_out,
  output logic                      frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  // -------------------------------------------------------------------------
  // Input position counters: the position of the pixel being accepted.
  // -------------------------------------------------------------------------
  logic [CW-1:0] col_cnt_q, col_cnt_d;
  logic [RW-1:0] row_cnt_q, row_cnt_d;
  logic          col_wrap;
  logic          row_wrap;

  assign col_wrap = (col_cnt_q == COL_LAST);
  assign row_wrap = (row_cnt_q == ROW_LAST);

  // NOTE: every signal assigned in an always_comb block first receives a
  // default. A path that leaves a signal unassigned would infer a latch.
  always_comb begin
    col_cnt_d = col_cnt_q;
    row_cnt_d = row_cnt_q;
    if (valid_in) begin
      if (col_wrap) begin
        col_cnt_d = '0;
        row_cnt_d = row_wrap ? '0 : row_cnt_q + RW'(1);
      end else begin
        col_cnt_d = col_cnt_q + CW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. All flops
  // then sample their inputs at the same edge, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt_q <= '0;
      row_cnt_q <= '0;
    end else begin
      col_cnt_q <= col_cnt_d;
      row_cnt_q <= row_cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Line buffers. lb1 holds line row-1 and lb2 holds line row-2, and both
  // are indexed by column. The read is combinational, so the write of the
  // same address at this edge sees the old value (read-before-write). The
  // line-1 value then cascades into line 2.
  // -------------------------------------------------------------------------
  logic [PIX_W-1:0] lb1_mem [IMG_W];
  logic [PIX_W-1:0] lb2_mem [IMG_W];
  logic [PIX_W-1:0] lb1_rd;
  logic [PIX_W-1:0] lb2_rd;

  assign lb1_rd = lb1_mem[col_cnt_q];
  assign lb2_rd = lb2_mem[col_cnt_q];

  // NOTE: the line-buffer storage has no reset. Its contents reach the
  // outputs only after two complete lines have been written since the last
  // reset, so stale data is never emitted. Leaving the reset off also lets
  // the store map onto RAM.
  always_ff @(posedge clk) begin
    if (valid_in) begin
      lb1_mem[col_cnt_q] <= px_in;
      lb2_mem[col_cnt_q] <= lb1_rd;
    end
  end

  // -------------------------------------------------------------------------
  // Window register: 9 taps, index k = 3*r + c. On each accepted pixel every
  // row shifts toward c = 0, and column c = 2 loads the new vertical slice
  // {line row-2, line row-1, current pixel}.
  // -------------------------------------------------------------------------
  logic [PIX_W-1:0] win_q [9];
  logic [PIX_W-1:0] win_d [9];

  always_comb begin
    win_d = win_q;
    if (valid_in) begin
      for (int r = 0; r < 3; r++) begin
        win_d[3*r]     = win_q[3*r + 1];
        win_d[3*r + 1] = win_q[3*r + 2];
      end
      win_d[2] = lb2_rd;
      win_d[5] = lb1_rd;
      win_d[8] = px_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 9; k++) begin
        win_q[k] <= '0;
      end
    end else begin
      win_q <= win_d;
    end
  end

  // Flatten the next-state window for the output register.
  logic [9*PIX_W-1:0] win_flat_d;

  always_comb begin
    win_flat_d = '0;
    for (int k = 0; k < 9; k++) begin
      win_flat_d[k*PIX_W +: PIX_W] = win_d[k];
    end
  end

  // -------------------------------------------------------------------------
  // Emission. A window is complete only when the pixel has two lines above
  // it and two columns to its left. Columns 0 and 1 are suppressed because
  // the window still contains the right edge of the previous line there.
  // The centre is one row up and one column left of the accepted pixel.
  // -------------------------------------------------------------------------
  logic emit;
  logic last_px;

  assign emit    = valid_in && (row_cnt_q >= ROW_TWO) && (col_cnt_q >= COL_TWO);
  assign last_px = row_wrap && col_wrap;

  logic                 valid_out_q, valid_out_d;
  logic                 frame_done_q, frame_done_d;
  logic [9*PIX_W-1:0]   win_out_q, win_out_d;
  logic [RW-1:0]        row_out_q, row_out_d;
  logic [CW-1:0]        col_out_q, col_out_d;

  always_comb begin
    valid_out_d  = emit;
    frame_done_d = emit && last_px;
    win_out_d    = win_out_q;
    row_out_d    = row_out_q;
    col_out_d    = col_out_q;
    if (emit) begin
      win_out_d = win_flat_d;
      row_out_d = row_cnt_q - RW'(1);
      col_out_d = col_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out_q  <= 1'b0;
      frame_done_q <= 1'b0;
      win_out_q    <= '0;
      row_out_q    <= '0;
      col_out_q    <= '0;
    end else begin
      valid_out_q  <= valid_out_d;
      frame_done_q <= frame_done_d;
      win_out_q    <= win_out_d;
      row_out_q    <= row_out_d;
      col_out_q    <= col_out_d;
    end
  end

  assign valid_out  = valid_out_q;
  assign frame_done = frame_done_q;
  assign win_out    = win_out_q;
  assign row_out    = row_out_q;
  assign col_out    = col_out_q;

endmodule

// File: tb/tb_window3x3_linebuf.sv
// ---------------------------------------------------------------------------
// tb_window3x3_linebuf
//
// Directed bench for window3x3_linebuf. A 4x4 instance covers the detailed
// sequencing: first and last windows, idle gaps, back-to-back frames and
// mid-frame reset. A default 64x64 instance covers a full-size frame.
// Inputs are driven on the falling edge. Outputs are sampled 1 time unit
// after the rising edge that accepts a pixel.
// ---------------------------------------------------------------------------
module tb_window3x3_linebuf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // 4x4 instance
  logic        s_valid;
  logic [7:0]  s_px;
  logic        s_vout;
  logic [71:0] s_win;
  logic [1:0]  s_row;
  logic [1:0]  s_col;
  logic        s_fd;

  window3x3_linebuf #(.PIX_W(8), .IMG_W(4), .IMG_H(4)) u_small (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (s_valid),
    .px_in      (s_px),
    .valid_out  (s_vout),
    .win_out    (s_win),
    .row_out    (s_row),
    .col_out    (s_col),
    .frame_done (s_fd)
  );

  // 64x64 instance (default parameters)
  logic        b_valid;
  logic [7:0]  b_px;
  logic        b_vout;
  logic [71:0] b_win;
  logic [5:0]  b_row;
  logic [5:0]  b_col;
  logic        b_fd;

  window3x3_linebuf u_big (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (b_valid),
    .px_in      (b_px),
    .valid_out  (b_vout),
    .win_out    (b_win),
    .row_out    (b_row),
    .col_out    (b_col),
    .frame_done (b_fd)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_win4   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Expected 4x4 window after accepting pixel (r,c); pixel value = base+4*row+col.
  function automatic logic [71:0] exp_win4(input int r, input int c, input int base);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[(3*i+j)*8 +: 8] = 8'(base + (r-2+i)*4 + (c-2+j));
    return w;
  endfunction

  // Expected 64x64 window after accepting pixel (r,c); pixel value = (row+col) mod 256.
  function automatic logic [71:0] exp_win64(input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[(3*i+j)*8 +: 8] = 8'((r-2+i) + (c-2+j));
    return w;
  endfunction

  // Present one pixel to the 4x4 DUT and check the cycle that follows.
  task automatic push4(input int r, input int c, input int base, output logic [71:0] w);
    logic emit;
    @(negedge clk);
    s_valid = 1'b1;
    s_px    = 8'(base + r*4 + c);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    emit = (r >= 2) && (c >= 2);
    w = s_win;
    check("vout", {127'd0, s_vout}, {127'd0, emit});
    check("fdone", {127'd0, s_fd}, {127'd0, (r == 3) && (c == 3)});
    if (s_vout) n_win4++;
    if (emit) begin
      check("win", {56'd0, s_win}, {56'd0, exp_win4(r, c, base)});
      check("row", {126'd0, s_row}, 128'(r - 1));
      check("col", {126'd0, s_col}, 128'(c - 1));
    end
  endtask

  task automatic idle4(input int n);
    repeat (n) begin
      @(negedge clk);
      s_valid = 1'b0;
      @(posedge clk);
      #1;
      check("gap_vout", {127'd0, s_vout}, 128'd0);
      check("gap_fdone", {127'd0, s_fd}, 128'd0);
    end
  endtask

  task automatic frame4(input int base, input int max_gap,
                        output logic [71:0] first_w, output logic [71:0] last_w);
    logic [71:0] w;
    first_w = '0;
    last_w  = '0;
    n_win4  = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        if (max_gap > 0) idle4(int'($urandom_range(0, max_gap)));
        push4(r, c, base, w);
        if (r == 2 && c == 2) first_w = w;
        if (r == 3 && c == 3) last_w = w;
      end
    check("win_count", 128'(n_win4), 128'd4);
  endtask

  task automatic check_zero4(input string tag);
    check({tag, "_vout"}, {127'd0, s_vout}, 128'd0);
    check({tag, "_win"}, {56'd0, s_win}, 128'd0);
    check({tag, "_row"}, {126'd0, s_row}, 128'd0);
    check({tag, "_col"}, {126'd0, s_col}, 128'd0);
    check({tag, "_fdone"}, {127'd0, s_fd}, 128'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Hand-computed windows (concatenation lists k8 down to k0).
  localparam logic [71:0] FIRST0 = {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0};
  localparam logic [71:0] LAST0  = {8'd15, 8'd14, 8'd13, 8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5};
  localparam logic [71:0] FIRST16 = {8'd26, 8'd25, 8'd24, 8'd22, 8'd21, 8'd20, 8'd18, 8'd17, 8'd16};
  // 64x64 with value = row+col: centre (10,20) covers rows 9..11, cols 19..21.
  localparam logic [71:0] C10_20 = {8'd32, 8'd31, 8'd30, 8'd31, 8'd30, 8'd29, 8'd30, 8'd29, 8'd28};
  // centre (11,20) covers rows 10..12, cols 19..21.
  localparam logic [71:0] C11_20 = {8'd33, 8'd32, 8'd31, 8'd32, 8'd31, 8'd30, 8'd31, 8'd30, 8'd29};

  initial begin
    logic [71:0] fw, lw, w;
    logic [71:0] w1020, w1120;
    int nwin, nfd, nbad;

    rst = 1'b1; s_valid = 1'b0; s_px = '0; b_valid = 1'b0; b_px = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero4("rst");
    check("rst_big_vout", {127'd0, b_vout}, 128'd0);
    check("rst_big_win", {56'd0, b_win}, 128'd0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back frame, values 0..15.
    frame4(0, 0, fw, lw);
    check("first_win_f0", {56'd0, fw}, {56'd0, FIRST0});
    check("last_win_f0", {56'd0, lw}, {56'd0, LAST0});

    // The same frame with random 0-5 cycle gaps.
    frame4(0, 5, fw, lw);
    check("first_win_gap", {56'd0, fw}, {56'd0, FIRST0});
    check("last_win_gap", {56'd0, lw}, {56'd0, LAST0});
    idle4(3);

    // Two frames back-to-back, the second carrying values 16..31.
    frame4(0, 0, fw, lw);
    frame4(16, 0, fw, lw);
    check("first_win_f16", {56'd0, fw}, {56'd0, FIRST16});

    // Reset after 7 pixels, then restart at value 0.
    for (int i = 0; i < 7; i++) push4(i / 4, i % 4, 0, w);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_zero4("midrst");
    @(negedge clk);
    rst = 1'b0;
    frame4(0, 0, fw, lw);
    check("first_win_rst", {56'd0, fw}, {56'd0, FIRST0});
    check("last_win_rst", {56'd0, lw}, {56'd0, LAST0});

    // Reset coincident with an emitting pixel cancels that window.
    for (int i = 0; i < 10; i++) push4(i / 4, i % 4, 0, w);
    @(negedge clk);
    s_valid = 1'b1;
    s_px    = 8'd10;
    rst     = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    check_zero4("inflight");
    @(negedge clk);
    rst = 1'b0;
    frame4(0, 0, fw, lw);
    check("first_win_rst2", {56'd0, fw}, {56'd0, FIRST0});

    // Full 64x64 frame on the default-parameter instance.
    nwin = 0; nfd = 0; nbad = 0; w1020 = '0; w1120 = '0;
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 64; c++) begin
        @(negedge clk);
        b_valid = 1'b1;
        b_px    = 8'((r + c) % 256);
        @(posedge clk);
        #1;
        if (b_vout !== ((r >= 2) && (c >= 2))) nbad++;
        if (b_fd === 1'b1) nfd++;
        if (b_vout === 1'b1) begin
          nwin++;
          if (b_win !== exp_win64(r, c) || int'(b_row) != r - 1 || int'(b_col) != c - 1) nbad++;
          if (b_row == 6'd10 && b_col == 6'd20) w1020 = b_win;
          if (b_row == 6'd11 && b_col == 6'd20) w1120 = b_win;
        end
      end
    @(negedge clk);
    b_valid = 1'b0;
    check("big_windows", 128'(nwin), 128'd3844);
    check("big_fdone_count", 128'(nfd), 128'd1);
    check("big_bad", 128'(nbad), 128'd0);
    check("big_c10_20", {56'd0, w1020}, {56'd0, C10_20});
    check("big_c11_20", {56'd0, w1120}, {56'd0, C11_20});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
